mem_uart_ctrl: RTL and testbench

//  MEM-stage bus controller between the EX/MEM register and the board: maps pipeline loads/stores

---
 rtl/mem_uart_ctrl_pkg.sv | 29 ++
 rtl/mem_uart_ctrl_uart_wait_timer.sv | 29 ++
 rtl/mem_uart_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_uart_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_uart_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM/UART bus controller: FSM encoding,
// UART register addresses and status-word bit positions.
package mem_uart_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAM_RD,
    RAM_WR,
    U_RD,
    U_WR,
    U_WAIT_TBRE,
    U_WAIT_TSRE,
    DONE
  } ctrlState_e;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  localparam int STAT_TX_READY_BIT   = 0;
  localparam int STAT_DATA_READY_BIT = 1;

  localparam int unsigned WAIT_LIMIT_DEFAULT = 1023;

  // States that poll a UART handshake and are bounded by the wait timer.
  function automatic logic isWaitState(input ctrlState_e s);
    return s inside {U_RD, U_WAIT_TBRE, U_WAIT_TSRE};
  endfunction

endpackage

// File: rtl/mem_uart_ctrl_uart_wait_timer.sv
// Cycle counter bounding the UART wait states; timeout is raised on the last
// permitted cycle so the FSM leaves after exactly LIMIT cycles in a wait state.
module uart_wait_timer #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !timeout) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_uart_ctrl.sv
// MEM-stage bus controller: maps pipeline loads/stores onto Ram1 SRAM or the UART
// sharing the Ram1 data bus, and stalls the pipeline until the access completes.
module mem_uart_ctrl
  import mem_uart_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead2,
  input  logic        MemWrite2,
  input  logic [15:0] Result2,
  input  logic [15:0] DataIn2,
  output logic [15:0] DataOut2,
  output logic        Stall,
  output logic        Ram1_EN,
  output logic        Ram1_OE,
  output logic        Ram1_WE,
  output logic [17:0] Ram1_address,
  inout  wire  [15:0] Ram1_data,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  ctrlState_e  state, nextState;
  logic        request;
  logic        busDrive;
  logic [15:0] busOut;
  logic        loadDone;
  logic [15:0] loadVal;
  logic [15:0] statusWord;
  logic        timerClear, timerEnable, timerTimeout;

  assign request      = MemRead2 | MemWrite2;
  assign Ram1_address = {2'b00, Result2};
  assign Ram1_data    = busDrive ? busOut : 16'bz;
  assign Stall        = ((state == IDLE) && request) || !(state inside {IDLE, DONE});

  always_comb begin
    statusWord = '0;
    statusWord[STAT_TX_READY_BIT]   = tbre & tsre;
    statusWord[STAT_DATA_READY_BIT] = data_ready;
  end

  // NOTE: state and DataOut2 are flops, so they use non-blocking assignments;
  // every reader in this edge then sees the pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      DataOut2 <= '0;
    end else begin
      state <= nextState;
      if (loadDone) DataOut2 <= loadVal;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    nextState = state;
    Ram1_EN   = 1'b1;
    Ram1_OE   = 1'b1;
    Ram1_WE   = 1'b1;
    rdn       = 1'b1;
    wrn       = 1'b1;
    busDrive  = 1'b0;
    busOut    = '0;
    loadDone  = 1'b0;
    loadVal   = '0;
    unique case (state)
      IDLE: begin
        if (request) begin
          // A store wins when both request lines are set.
          if (Result2 == UART_STAT_ADDR) begin
            nextState = DONE;
            if (!MemWrite2) begin
              loadDone = 1'b1;
              loadVal  = statusWord;
            end
          end else if (Result2 == UART_DATA_ADDR) begin
            nextState = MemWrite2 ? U_WR : U_RD;
          end else begin
            nextState = MemWrite2 ? RAM_WR : RAM_RD;
          end
        end
      end
      RAM_RD: begin
        Ram1_EN   = 1'b0;
        Ram1_OE   = 1'b0;
        loadDone  = 1'b1;
        loadVal   = Ram1_data;
        nextState = DONE;
      end
      RAM_WR: begin
        Ram1_EN   = 1'b0;
        Ram1_WE   = 1'b0;
        busDrive  = 1'b1;
        busOut    = DataIn2;
        nextState = DONE;
      end
      U_RD: begin
        rdn = 1'b0;
        if (data_ready) begin
          loadDone  = 1'b1;
          loadVal   = {8'h00, Ram1_data[7:0]};
          nextState = DONE;
        end else if (timerTimeout) begin
          loadDone  = 1'b1;
          nextState = DONE;
        end
      end
      U_WR: begin
        wrn       = 1'b0;
        busDrive  = 1'b1;
        busOut    = {8'h00, DataIn2[7:0]};
        nextState = U_WAIT_TBRE;
      end
      U_WAIT_TBRE: begin
        if (tbre)              nextState = U_WAIT_TSRE;
        else if (timerTimeout) nextState = DONE;
      end
      U_WAIT_TSRE: begin
        if (tsre || timerTimeout) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Restart the count whenever a wait state is entered, including TBRE -> TSRE.
  assign timerClear  = isWaitState(nextState) && (nextState != state);
  assign timerEnable = isWaitState(state);

  uart_wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) waitTimer (
    .Clk    (Clk),
    .Rst    (Rst),
    .clear  (timerClear),
    .enable (timerEnable),
    .timeout(timerTimeout)
  );

endmodule

// File: tb/tb_mem_uart_ctrl.sv
// Self-checking bench for mem_uart_ctrl: a transaction-level model predicts every
// cycle's strobes, Stall, bus value and DataOut2; a negedge process compares them.
module tb_mem_uart_ctrl;

  localparam int WAIT_LIMIT = 1023;
  localparam logic [15:0] BUS_IDLE = 16'hFFFF;  // undriven bus reads as the pull-up

  logic        Clk = 1'b0;
  logic        Rst;
  logic        MemRead2, MemWrite2;
  logic [15:0] Result2, DataIn2;
  logic [15:0] DataOut2;
  logic        Stall;
  logic        Ram1_EN, Ram1_OE, Ram1_WE;
  logic [17:0] Ram1_address;
  wire  [15:0] Ram1_data;
  logic        rdn, wrn;
  logic        data_ready, tbre, tsre;

  logic        tbDrv;
  logic [15:0] tbVal;

  assign Ram1_data = tbDrv ? tbVal : 16'bz;
  pullup busPull (Ram1_data);

  always #5 Clk = ~Clk;

  mem_uart_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .MemRead2    (MemRead2),
    .MemWrite2   (MemWrite2),
    .Result2     (Result2),
    .DataIn2     (DataIn2),
    .DataOut2    (DataOut2),
    .Stall       (Stall),
    .Ram1_EN     (Ram1_EN),
    .Ram1_OE     (Ram1_OE),
    .Ram1_WE     (Ram1_WE),
    .Ram1_address(Ram1_address),
    .Ram1_data   (Ram1_data),
    .rdn         (rdn),
    .wrn         (wrn),
    .data_ready  (data_ready),
    .tbre        (tbre),
    .tsre        (tsre)
  );

  typedef struct {
    logic        stall, en, oe, we, rdnV, wrnV;
    logic [15:0] bus;
    logic [15:0] dout;
    logic [17:0] addr;
  } expRec_t;

  expRec_t     expQ[$];
  expRec_t     cur;
  logic [15:0] sram[logic [15:0]];
  logic [15:0] curDout;

  int tests = 0;
  int fails = 0;
  int rdnLow, wrnLow, weLow, enLow, stallHigh;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic expRec_t mk(input logic stall, en, oe, we, rdnV, wrnV,
                                 input logic [15:0] bus);
    expRec_t r;
    r.stall = stall; r.en = en; r.oe = oe; r.we = we; r.rdnV = rdnV; r.wrnV = wrnV;
    r.bus = bus; r.dout = curDout; r.addr = {2'b00, Result2};
    return r;
  endfunction

  always @(negedge Clk) begin
    if (expQ.size() != 0) begin
      cur = expQ.pop_front();
      check("stall",    Stall,        cur.stall);
      check("ram_en",   Ram1_EN,      cur.en);
      check("ram_oe",   Ram1_OE,      cur.oe);
      check("ram_we",   Ram1_WE,      cur.we);
      check("rdn",      rdn,          cur.rdnV);
      check("wrn",      wrn,          cur.wrnV);
      check("bus",      Ram1_data,    cur.bus);
      check("dataout",  DataOut2,     cur.dout);
      check("address",  Ram1_address, cur.addr);
      check("bus_excl", 18'(!Ram1_EN && (!rdn || !wrn)), 18'd0);
    end
    if (rdn === 1'b0)     rdnLow++;
    if (wrn === 1'b0)     wrnLow++;
    if (Ram1_WE === 1'b0) weLow++;
    if (Ram1_EN === 1'b0) enLow++;
    if (Stall === 1'b1)   stallHigh++;
  end

  task automatic runCycle(input expRec_t e);
    expQ.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic clearCounts();
    rdnLow = 0; wrnLow = 0; weLow = 0; enLow = 0; stallHigh = 0;
  endtask

  task automatic idleCycle();
    MemRead2 = 1'b0; MemWrite2 = 1'b0;
    Result2 = 16'($urandom); DataIn2 = 16'($urandom);
    data_ready = 1'($urandom); tbre = 1'($urandom); tsre = 1'($urandom);
    tbDrv = 1'b0;
    runCycle(mk(0, 1, 1, 1, 1, 1, BUS_IDLE));
  endtask

  task automatic ramLoad(input logic [15:0] addr);
    MemRead2 = 1'b1; MemWrite2 = 1'b0; Result2 = addr; DataIn2 = 16'($urandom);
    if (!sram.exists(addr)) sram[addr] = 16'($urandom);
    runCycle(mk(1, 1, 1, 1, 1, 1, BUS_IDLE));
    tbDrv = 1'b1; tbVal = sram[addr];
    runCycle(mk(1, 0, 0, 1, 1, 1, sram[addr]));
    tbDrv = 1'b0; curDout = sram[addr];
    runCycle(mk(0, 1, 1, 1, 1, 1, BUS_IDLE));
  endtask

  task automatic ramStore(input logic [15:0] addr, input logic [15:0] data);
    MemWrite2 = 1'b1; MemRead2 = 1'($urandom); Result2 = addr; DataIn2 = data;
    runCycle(mk(1, 1, 1, 1, 1, 1, BUS_IDLE));
    runCycle(mk(1, 0, 1, 0, 1, 1, data));
    sram[addr] = data;
    runCycle(mk(0, 1, 1, 1, 1, 1, BUS_IDLE));
  endtask

  task automatic statusAccess(input logic isRead, input logic dr, te, se);
    MemRead2 = isRead ? 1'b1 : 1'($urandom); MemWrite2 = !isRead;
    Result2 = 16'hBF01; DataIn2 = 16'($urandom);
    data_ready = dr; tbre = te; tsre = se;
    runCycle(mk(1, 1, 1, 1, 1, 1, BUS_IDLE));
    if (isRead) curDout = 16'(dr) * 16'd2 + 16'(te & se);
    runCycle(mk(0, 1, 1, 1, 1, 1, BUS_IDLE));
  endtask

  // d = cycles spent in the read wait before data_ready rises
  task automatic uartLoad(input int d, input logic [15:0] val);
    bit ok = 0;
    MemRead2 = 1'b1; MemWrite2 = 1'b0; Result2 = 16'hBF00; DataIn2 = 16'($urandom);
    data_ready = 1'b0;
    runCycle(mk(1, 1, 1, 1, 1, 1, BUS_IDLE));
    for (int k = 0; k < WAIT_LIMIT; k++) begin
      data_ready = (k >= d); tbDrv = 1'b1; tbVal = val;
      runCycle(mk(1, 1, 1, 1, 0, 1, val));
      if (k >= d) begin ok = 1; break; end
    end
    tbDrv = 1'b0; data_ready = 1'b0;
    curDout = ok ? (val & 16'h00FF) : 16'h0000;
    runCycle(mk(0, 1, 1, 1, 1, 1, BUS_IDLE));
  endtask

  // a/b = cycles spent waiting before tbre/tsre rise; rstAt >= 0 pulses Rst in that TSRE cycle
  task automatic uartStore(input logic [15:0] data, input int a, input int b, input int rstAt);
    bit ok = 0;
    MemWrite2 = 1'b1; MemRead2 = 1'($urandom); Result2 = 16'hBF00; DataIn2 = data;
    tbre = 1'b0; tsre = 1'b0;
    runCycle(mk(1, 1, 1, 1, 1, 1, BUS_IDLE));
    runCycle(mk(1, 1, 1, 1, 1, 0, data & 16'h00FF));
    for (int k = 0; k < WAIT_LIMIT; k++) begin
      tbre = (k >= a);
      runCycle(mk(1, 1, 1, 1, 1, 1, BUS_IDLE));
      if (k >= a) begin ok = 1; break; end
    end
    if (ok) begin
      for (int k = 0; k < WAIT_LIMIT; k++) begin
        tsre = (k >= b);
        if (k == rstAt) begin
          Rst = 1'b1;
          runCycle(mk(1, 1, 1, 1, 1, 1, BUS_IDLE));
          Rst = 1'b0; MemWrite2 = 1'b0; MemRead2 = 1'b0; curDout = 16'h0000;
          runCycle(mk(0, 1, 1, 1, 1, 1, BUS_IDLE));
          return;
        end
        runCycle(mk(1, 1, 1, 1, 1, 1, BUS_IDLE));
        if (k >= b) break;
      end
    end
    runCycle(mk(0, 1, 1, 1, 1, 1, BUS_IDLE));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; MemRead2 = 1'b0; MemWrite2 = 1'b0; Result2 = '0; DataIn2 = '0;
    data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0; tbDrv = 1'b0; tbVal = '0;
    curDout = 16'h0000;
    clearCounts();
    @(posedge Clk); #1;
    runCycle(mk(0, 1, 1, 1, 1, 1, BUS_IDLE));  // still in reset: reset outputs
    Rst = 1'b0;
    idleCycle();

    // Stall counts include the cycle the request is accepted in IDLE.
    clearCounts();
    ramStore(16'h0040, 16'h1234);
    check("ram_store_we_cycles", 18'(weLow), 18'd1);
    check("ram_store_stall_cycles", 18'(stallHigh), 18'd2);

    clearCounts();
    ramLoad(16'h0040);
    check("ram_load_value", DataOut2, 18'h01234);
    check("ram_load_stall_cycles", 18'(stallHigh), 18'd2);

    clearCounts();
    statusAccess(1'b1, 1'b0, 1'b1, 1'b1);
    check("status_value", DataOut2, 18'h00001);
    check("status_stall_cycles", 18'(stallHigh), 18'd1);

    clearCounts();
    uartStore(16'h0041, 5, 8, -1);
    check("uart_tx_wrn_cycles", 18'(wrnLow), 18'd1);
    check("uart_tx_stall_cycles", 18'(stallHigh), 18'd17);

    clearCounts();
    uartLoad(3, 16'h5A5A);
    check("uart_rx_value", DataOut2, 18'h0005A);
    check("uart_rx_rdn_cycles", 18'(rdnLow), 18'd4);
    check("uart_rx_en_low_cycles", 18'(enLow), 18'd0);

    clearCounts();
    uartStore(16'h00C3, WAIT_LIMIT, 0, -1);  // tbre never rises
    check("tx_timeout_stall_cycles", 18'(stallHigh), 18'(WAIT_LIMIT + 2));
    check("tx_timeout_keeps_dataout", DataOut2, 18'h0005A);
    idleCycle();

    uartLoad(WAIT_LIMIT, 16'h77AB);           // data_ready never rises
    check("rx_timeout_value", DataOut2, 18'h00000);

    ramLoad(16'h0040);
    uartStore(16'h0099, 1, 10, 3);            // reset lands in the TSRE wait
    check("reset_mid_access_dataout", DataOut2, 18'h00000);
    check("reset_mid_access_stall", Stall, 18'd0);
    idleCycle();

    for (int i = 0; i < 80; i++) begin
      int kind = int'($urandom_range(0, 6));
      case (kind)
        0: ramStore(16'(16'h0040 + $urandom_range(0, 15)), 16'($urandom));
        1: ramLoad(16'(16'h0040 + $urandom_range(0, 15)));
        2: statusAccess(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        3: statusAccess(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        4: uartLoad(int'($urandom_range(0, 6)), 16'($urandom));
        5: uartStore(16'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), -1);
        default: idleCycle();
      endcase
      repeat ($urandom_range(0, 2)) idleCycle();
    end
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
